// File: rtl/pila_datos.sv
// pila_datos: LIFO stack of PROFUNDIDAD words of ANCHO bits, with a registered
// top-of-stack output and a sticky overflow/underflow flag.
// Ports:
//   i_Clk, i_Reset (async, active-high)
//   i_Push, i_Pop      request pair: 00 idle, 10 push, 01 pop, 11 replace top
//   i_Dato_a_stack     word to push / replace
//   i_Limpiar_error    synchronous clear of o_Error (a new error wins)
//   o_Senal_a_stack    registered top word, 0 when empty
//   o_Cuenta           number of valid entries
//   o_Vacio, o_Lleno   decoded from the registered count
//   o_Error            sticky overflow/underflow flag
module pila_datos #(
    parameter int unsigned ANCHO       = 8,
    parameter int unsigned PROFUNDIDAD = 8
) (
    input  logic                             i_Clk,
    input  logic                             i_Reset,
    input  logic                             i_Push,
    input  logic                             i_Pop,
    input  logic [ANCHO-1:0]                 i_Dato_a_stack,
    input  logic                             i_Limpiar_error,
    output logic [ANCHO-1:0]                 o_Senal_a_stack,
    output logic [$clog2(PROFUNDIDAD):0]     o_Cuenta,
    output logic                             o_Vacio,
    output logic                             o_Lleno,
    output logic                             o_Error
);

    localparam int unsigned IW = $clog2(PROFUNDIDAD);
    localparam int unsigned CW = IW + 1;

    logic [ANCHO-1:0] r_Memoria [PROFUNDIDAD];
    logic [CW-1:0]    r_Cuenta;
    logic [ANCHO-1:0] r_Senal;
    logic             r_Error;

    logic             w_Vacio;
    logic             w_Lleno;
    logic [IW-1:0]    w_Idx_top;
    logic [IW-1:0]    w_Idx_bajo;
    logic             w_Escribir;
    logic [IW-1:0]    w_Indice;
    logic [CW-1:0]    w_Cuenta_sig;
    logic [ANCHO-1:0] w_Senal_sig;
    logic             w_Error_set;

    assign w_Vacio    = (r_Cuenta == '0);
    assign w_Lleno    = (r_Cuenta == CW'(PROFUNDIDAD));
    // Index of the current top and of the entry just beneath it; only used when valid.
    assign w_Idx_top  = IW'(r_Cuenta - CW'(1));
    assign w_Idx_bajo = IW'(r_Cuenta - CW'(2));

    // Operation decode: next count, next top word, array write and error set.
    always_comb begin
        w_Escribir   = 1'b0;
        w_Indice     = IW'(r_Cuenta);
        w_Cuenta_sig = r_Cuenta;
        w_Senal_sig  = r_Senal;
        w_Error_set  = 1'b0;
        case ({i_Push, i_Pop})
            2'b10: begin
                if (w_Lleno) begin
                    w_Error_set = 1'b1;
                end else begin
                    w_Escribir   = 1'b1;
                    w_Cuenta_sig = r_Cuenta + CW'(1);
                    w_Senal_sig  = i_Dato_a_stack;
                end
            end
            2'b01: begin
                if (w_Vacio) begin
                    w_Error_set = 1'b1;
                end else begin
                    w_Cuenta_sig = r_Cuenta - CW'(1);
                    // Popping the last entry must show 0, never a stale word.
                    w_Senal_sig  = (r_Cuenta == CW'(1)) ? '0 : r_Memoria[w_Idx_bajo];
                end
            end
            2'b11: begin
                w_Escribir  = 1'b1;
                w_Senal_sig = i_Dato_a_stack;
                if (w_Vacio) begin
                    // Replace on an empty stack acts as a push into slot 0.
                    w_Cuenta_sig = CW'(1);
                end else begin
                    w_Indice = w_Idx_top;
                end
            end
            default: ;
        endcase
    end

    // Storage array; contents are not reset, the count alone defines validity.
    always_ff @(posedge i_Clk) begin
        if (w_Escribir && !i_Reset) begin
            r_Memoria[w_Indice] <= i_Dato_a_stack;
        end
    end

    // Count, top word and sticky error.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Cuenta <= '0;
            r_Senal  <= '0;
            r_Error  <= 1'b0;
        end else begin
            r_Cuenta <= w_Cuenta_sig;
            r_Senal  <= w_Senal_sig;
            if (w_Error_set) begin
                r_Error <= 1'b1;
            end else if (i_Limpiar_error) begin
                r_Error <= 1'b0;
            end
        end
    end

    assign o_Senal_a_stack = r_Senal;
    assign o_Cuenta        = r_Cuenta;
    assign o_Vacio         = w_Vacio;
    assign o_Lleno         = w_Lleno;
    assign o_Error         = r_Error;

endmodule

// File: tb/tb_pila_datos.sv
// Directed bench for pila_datos (ANCHO=8, PROFUNDIDAD=8).
module tb_pila_datos;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic       i_Push;
    logic       i_Pop;
    logic [7:0] i_Dato_a_stack;
    logic       i_Limpiar_error;
    logic [7:0] o_Senal_a_stack;
    logic [3:0] o_Cuenta;
    logic       o_Vacio;
    logic       o_Lleno;
    logic       o_Error;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pila_datos #(.ANCHO(8), .PROFUNDIDAD(8)) dut (
        .i_Clk           (i_Clk),
        .i_Reset         (i_Reset),
        .i_Push          (i_Push),
        .i_Pop           (i_Pop),
        .i_Dato_a_stack  (i_Dato_a_stack),
        .i_Limpiar_error (i_Limpiar_error),
        .o_Senal_a_stack (o_Senal_a_stack),
        .o_Cuenta        (o_Cuenta),
        .o_Vacio         (o_Vacio),
        .o_Lleno         (o_Lleno),
        .o_Error         (o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Apply one request for exactly one rising edge; returns at the next falling edge.
    task automatic ciclo(input logic push, input logic pop, input logic [7:0] d, input logic clr);
        i_Push          = push;
        i_Pop           = pop;
        i_Dato_a_stack  = d;
        i_Limpiar_error = clr;
        @(negedge i_Clk);
        i_Push          = 1'b0;
        i_Pop           = 1'b0;
        i_Dato_a_stack  = 8'h00;
        i_Limpiar_error = 1'b0;
    endtask

    task automatic estado(input string tag, input logic [7:0] top, input logic [3:0] cnt,
                          input logic vac, input logic lle, input logic err);
        chequear({tag, ".top"},   32'(o_Senal_a_stack), 32'(top));
        chequear({tag, ".cnt"},   32'(o_Cuenta),        32'(cnt));
        chequear({tag, ".vacio"}, 32'(o_Vacio),         32'(vac));
        chequear({tag, ".lleno"}, 32'(o_Lleno),         32'(lle));
        chequear({tag, ".error"}, 32'(o_Error),         32'(err));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_Reset = 1'b1;
        i_Push = 1'b0; i_Pop = 1'b0; i_Dato_a_stack = 8'h00; i_Limpiar_error = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        estado("reset", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        i_Reset = 1'b0;

        // Three pushes, then three pops.
        ciclo(1'b1, 1'b0, 8'h11, 1'b0); chequear("push11", 32'(o_Senal_a_stack), 32'h11);
        ciclo(1'b1, 1'b0, 8'h22, 1'b0); chequear("push22", 32'(o_Senal_a_stack), 32'h22);
        ciclo(1'b1, 1'b0, 8'h33, 1'b0); estado("push33", 8'h33, 4'd3, 1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b0, 8'hEE, 1'b0); estado("idle",   8'h33, 4'd3, 1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b1, 8'h00, 1'b0); estado("pop1",   8'h22, 4'd2, 1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b1, 8'h00, 1'b0); estado("pop2",   8'h11, 4'd1, 1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b1, 8'h00, 1'b0); estado("pop3",   8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // Fill to the top, then overflow.
        for (int k = 0; k < 8; k++) begin
            ciclo(1'b1, 1'b0, 8'(8'hA0 + k), 1'b0);
            chequear("fill.top", 32'(o_Senal_a_stack), 32'(8'hA0 + k));
        end
        estado("full",     8'hA7, 4'd8, 1'b0, 1'b1, 1'b0);
        ciclo(1'b1, 1'b0, 8'hFF, 1'b0); estado("overflow", 8'hA7, 4'd8, 1'b0, 1'b1, 1'b1);
        ciclo(1'b0, 1'b1, 8'h00, 1'b0); estado("pop_full", 8'hA6, 4'd7, 1'b0, 1'b0, 1'b1);
        ciclo(1'b0, 1'b0, 8'h00, 1'b1); chequear("clear", 32'(o_Error), 32'h0);

        // Drain the remaining seven entries.
        for (int k = 6; k >= 0; k--) begin
            ciclo(1'b0, 1'b1, 8'h00, 1'b0);
            chequear("drain.top", 32'(o_Senal_a_stack), (k == 0) ? 32'h0 : 32'(8'hA0 + k - 1));
        end
        estado("drained", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);

        // Underflow with simultaneous clear: set wins.
        ciclo(1'b0, 1'b1, 8'h00, 1'b1); estado("underflow", 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
        ciclo(1'b0, 1'b0, 8'h00, 1'b1); chequear("clear2", 32'(o_Error), 32'h0);

        // Replace on non-empty and on empty stacks.
        ciclo(1'b1, 1'b0, 8'h55, 1'b0); chequear("push55", 32'(o_Senal_a_stack), 32'h55);
        ciclo(1'b1, 1'b1, 8'h66, 1'b0); estado("repl66", 8'h66, 4'd1, 1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b1, 8'h00, 1'b0); estado("pop66",  8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        ciclo(1'b1, 1'b1, 8'h77, 1'b0); estado("repl77", 8'h77, 4'd1, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 1'b1, 8'h78, 1'b0); estado("repl78", 8'h78, 4'd1, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 1'b0, 8'h01, 1'b0);
        ciclo(1'b0, 1'b1, 8'h00, 1'b0); chequear("pop_to78", 32'(o_Senal_a_stack), 32'h78);

        // Build five entries, then reset asynchronously with a push pending.
        for (int k = 1; k <= 4; k++) ciclo(1'b1, 1'b0, 8'(k), 1'b0);
        estado("five", 8'h04, 4'd5, 1'b0, 1'b0, 1'b0);
        i_Push = 1'b1; i_Dato_a_stack = 8'hEE;
        #2 i_Reset = 1'b1;
        #1 estado("async_rst", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        @(negedge i_Clk);
        estado("rst_hold", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        i_Push = 1'b0; i_Dato_a_stack = 8'h00;
        i_Reset = 1'b0;
        ciclo(1'b1, 1'b0, 8'h09, 1'b0); estado("after_rst", 8'h09, 4'd1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
